// File: rtl/act_pkg.sv
// act_pkg: shared types and helpers for the activation layers.
//   act_mode_e     - per-frame activation selector
//   ACT_BITWIDTH   - default element width
//   popcount_signs - counts set bits of a sign-bit vector (up to ACT_MAX_LANES lanes)
package act_pkg;

  typedef enum logic [1:0] {
    ACT_PASS  = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_LEAKY = 2'd2,
    ACT_CLAMP = 2'd3
  } act_mode_e;

  localparam int ACT_BITWIDTH  = 32;
  localparam int ACT_MAX_LANES = 64;

  // Callers zero-extend their sign vector to ACT_MAX_LANES bits.
  function automatic logic [6:0] popcount_signs(input logic [ACT_MAX_LANES-1:0] signs);
    logic [6:0] cnt;
    cnt = 7'd0;
    for (int i = 0; i < ACT_MAX_LANES; i++) begin
      cnt = cnt + {6'd0, signs[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/act_lane.sv
// act_lane: combinational activation of one signed element.
//   x    in  BITWIDTH  signed two's complement element
//   mode in  2         act_mode_e selector
//   y    out BITWIDTH  activated element, same width and scale as x
module act_lane import act_pkg::*; #(
  parameter int BITWIDTH    = ACT_BITWIDTH,
  parameter int LEAKY_SHIFT = 3,
  parameter int CLAMP_MAX   = 6
) (
  input  logic [BITWIDTH-1:0] x,
  input  act_mode_e           mode,
  output logic [BITWIDTH-1:0] y
);

  localparam logic signed [BITWIDTH-1:0] CLAMP_V = BITWIDTH'(CLAMP_MAX);

  logic signed [BITWIDTH-1:0] x_sgn_s;
  logic signed [BITWIDTH-1:0] leaky_s;
  logic                       neg_s;
  logic                       over_s;

  assign x_sgn_s = x;
  assign neg_s   = x[BITWIDTH-1];
  assign over_s  = (x_sgn_s > CLAMP_V);
  // Arithmetic shift floors toward minus infinity, e.g. -1 stays -1.
  assign leaky_s = x_sgn_s >>> LEAKY_SHIFT;

  // Per-mode activation function.
  always_comb begin
    y = x;
    case (mode)
      ACT_PASS: y = x;
      ACT_RELU: begin
        if (neg_s) y = {BITWIDTH{1'b0}};
        else       y = x;
      end
      ACT_LEAKY: begin
        if (neg_s) y = leaky_s;
        else       y = x;
      end
      ACT_CLAMP: begin
        if (neg_s)       y = {BITWIDTH{1'b0}};
        else if (over_s) y = CLAMP_V;
        else             y = x;
      end
      default: y = x;
    endcase
  end

endmodule

// File: rtl/activation_stream_unit.sv
// activation_stream_unit: two-stage streaming activation over LANES elements per beat.
//   clk, rst         clock, synchronous active-high reset
//   cfg_mode         activation mode, captured on the first beat of each frame
//   in_data/in_valid/in_ready     input beat handshake (lane i at [i*BITWIDTH +: BITWIDTH])
//   out_data/out_valid/out_ready  output beat handshake, same lane packing
//   out_last         marks the final beat of each FRAME_BEATS-beat frame
//   neg_count/neg_count_valid     count of negative inputs in the frame, pulsed when
//                                 that frame's last beat leaves; value held afterwards
module activation_stream_unit import act_pkg::*; #(
  parameter int BITWIDTH    = ACT_BITWIDTH,
  parameter int LANES       = 4,
  parameter int FRAME_BEATS = 3,
  parameter int LEAKY_SHIFT = 3,
  parameter int CLAMP_MAX   = 6,
  parameter int CNT_W       = $clog2(FRAME_BEATS*LANES+1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                cfg_mode,
  input  logic [LANES*BITWIDTH-1:0] in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [LANES*BITWIDTH-1:0] out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic [CNT_W-1:0]          neg_count,
  output logic                      neg_count_valid
);

  localparam int DW        = LANES*BITWIDTH;
  localparam int BEAT_W    = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_BEATS-1);

  // Frame tracking
  logic [BEAT_W-1:0]        beat_cnt_r;
  act_mode_e                frame_mode_r;
  logic [CNT_W-1:0]         neg_acc_r;
  logic [CNT_W-1:0]         neg_count_r;

  // Stage 1: raw beat plus its mode, last flag and (on last beats) the frame total
  logic                     s1_valid_r;
  logic [DW-1:0]            s1_data_r;
  act_mode_e                s1_mode_r;
  logic                     s1_last_r;
  logic [CNT_W-1:0]         s1_neg_r;

  // Stage 2: activated beat
  logic                     s2_valid_r;
  logic [DW-1:0]            s2_data_r;
  logic                     s2_last_r;
  logic [CNT_W-1:0]         s2_neg_r;

  logic                     s2_ready_s;
  logic                     in_ready_s;
  logic                     in_fire_s;
  logic                     is_last_s;
  act_mode_e                beat_mode_s;
  logic [ACT_MAX_LANES-1:0] sign_vec_s;
  logic [CNT_W-1:0]         beat_neg_s;
  logic [CNT_W-1:0]         neg_total_s;
  logic [DW-1:0]            act_data_s;
  logic                     neg_count_valid_s;

  assign s2_ready_s  = !s2_valid_r || out_ready;
  // S1 can take a beat when empty or when its beat moves into S2 this cycle.
  assign in_ready_s  = !s1_valid_r || s2_ready_s;
  assign in_fire_s   = in_valid && in_ready_s;
  assign is_last_s   = (beat_cnt_r == LAST_BEAT);
  assign beat_neg_s  = CNT_W'(popcount_signs(sign_vec_s));
  assign neg_total_s = neg_acc_r + beat_neg_s;
  assign neg_count_valid_s = s2_valid_r && out_ready && s2_last_r;

  // Mode for the incoming beat: live cfg_mode on beat 0, frame-latched mode otherwise.
  always_comb begin
    beat_mode_s = frame_mode_r;
    if (beat_cnt_r == {BEAT_W{1'b0}}) beat_mode_s = act_mode_e'(cfg_mode);
    else                              beat_mode_s = frame_mode_r;
  end

  // Gather the sign bit of every input lane.
  always_comb begin
    sign_vec_s = {ACT_MAX_LANES{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      sign_vec_s[i] = in_data[i*BITWIDTH + BITWIDTH - 1];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    act_lane #(
      .BITWIDTH   (BITWIDTH),
      .LEAKY_SHIFT(LEAKY_SHIFT),
      .CLAMP_MAX  (CLAMP_MAX)
    ) u_lane (
      .x   (s1_data_r[g*BITWIDTH +: BITWIDTH]),
      .mode(s1_mode_r),
      .y   (act_data_s[g*BITWIDTH +: BITWIDTH])
    );
  end

  // Beat counter, frame mode latch and negative-element accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_r   <= {BEAT_W{1'b0}};
      frame_mode_r <= ACT_PASS;
      neg_acc_r    <= {CNT_W{1'b0}};
    end else if (in_fire_s) begin
      if (beat_cnt_r == {BEAT_W{1'b0}}) frame_mode_r <= beat_mode_s;
      if (is_last_s) begin
        // The frame total rides down the pipeline with the last beat.
        beat_cnt_r <= {BEAT_W{1'b0}};
        neg_acc_r  <= {CNT_W{1'b0}};
      end else begin
        beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
        neg_acc_r  <= neg_total_s;
      end
    end
  end

  // Two-stage pipeline; each stage loads when empty or when draining this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= {DW{1'b0}};
      s1_mode_r  <= ACT_PASS;
      s1_last_r  <= 1'b0;
      s1_neg_r   <= {CNT_W{1'b0}};
      s2_valid_r <= 1'b0;
      s2_data_r  <= {DW{1'b0}};
      s2_last_r  <= 1'b0;
      s2_neg_r   <= {CNT_W{1'b0}};
    end else begin
      if (in_ready_s) begin
        s1_valid_r <= in_valid;
        if (in_valid) begin
          s1_data_r <= in_data;
          s1_mode_r <= beat_mode_s;
          s1_last_r <= is_last_s;
          s1_neg_r  <= neg_total_s;
        end
      end
      if (s2_ready_s) begin
        s2_valid_r <= s1_valid_r;
        s2_last_r  <= s1_valid_r && s1_last_r;
        if (s1_valid_r) begin
          s2_data_r <= act_data_s;
          s2_neg_r  <= s1_neg_r;
        end
      end
    end
  end

  // Completed-frame count, updated as the frame's last beat leaves.
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_count_r <= {CNT_W{1'b0}};
    end else if (neg_count_valid_s) begin
      neg_count_r <= s2_neg_r;
    end
  end

  // During the pulse the fresh total is shown directly; otherwise the held value.
  always_comb begin
    neg_count = neg_count_r;
    if (neg_count_valid_s) neg_count = s2_neg_r;
    else                   neg_count = neg_count_r;
  end

  assign in_ready        = in_ready_s;
  assign out_data        = s2_data_r;
  assign out_valid       = s2_valid_r;
  assign out_last        = s2_last_r;
  assign neg_count_valid = neg_count_valid_s;

endmodule

// File: doc/activation_stream_unit.md
Name: activation_stream_unit

Overview:
Streaming, pipelined successor to the fixed 10-element combinational ReLU layer. It accepts LANES signed fixed-point feature-map elements per beat over a valid/ready handshake and applies a per-frame-selectable activation: pass, ReLU, leaky ReLU or clamped ReLU. It marks the last beat of each FRAME_BEATS-beat frame and reports a per-frame count of negative inputs. It sits between a conv/FC accumulator output and the next layer's input buffer.

Parameters:
BITWIDTH, 32, element width, signed two's complement
LANES, 4, elements per beat
FRAME_BEATS, 3, beats per frame; frame = FRAME_BEATS*LANES elements; must be >=1
LEAKY_SHIFT, 3, negative-slope arithmetic right shift (slope 2^-LEAKY_SHIFT)
CLAMP_MAX, 6, upper clamp for mode CLAMP, same scale as data
CNT_W, $clog2(FRAME_BEATS*LANES+1), width of neg_count (derived)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cfg_mode  in  2  0=PASS 1=RELU 2=LEAKY 3=CLAMP; sampled on first beat of each frame
in_data  in  LANES*BITWIDTH  lane i = bits [i*BITWIDTH +: BITWIDTH]
in_valid  in  1  input beat valid
in_ready  out  1  unit can accept a beat
out_data  out  LANES*BITWIDTH  activated elements, same lane packing
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
out_last  out  1  high with final beat of a frame
neg_count  out  CNT_W  number of input elements <0 in the frame just completed
neg_count_valid  out  1  one-cycle pulse carrying neg_count

Behaviour:
- Single clock domain; clock and reset as stated in Ports. Reset is synchronous, active-high, and applied at the same edge it is sampled.
- Reset values: out_data=0, out_valid=0, out_last=0, neg_count=0, neg_count_valid=0. in_ready=1 in the first cycle after reset deasserts.
- Fire: in_fire = in_valid&in_ready; out_fire = out_valid&out_ready.
- Pipeline has 2 stages: S1 registers input data, the frame-latched mode and the last flag. S2 registers the activated result.
- Each stage loads when it is empty or its contents leave this cycle. in_ready = !S1_valid || S1 advances. Full throughput: 1 beat/cycle when out_ready=1. Latency in_fire to out_valid is 2 cycles.
- Data is held stable while out_valid=1 and out_ready=0. No beats are dropped or duplicated.
- Input beat counter runs 0..FRAME_BEATS-1 on in_fire and wraps to 0 after the last beat. With FRAME_BEATS=1 every beat is last.
- cfg_mode is latched on an in_fire with beat counter = 0 and applied to every beat of that frame. Changes mid-frame are ignored.
- Per-lane function (signed compare):
  - PASS: y=x.
  - RELU: y = x<0 ? 0 : x.
  - LEAKY: y = x<0 ? x>>>LEAKY_SHIFT : x (floor rounding).
  - CLAMP: y = x<0 ? 0 : (x>CLAMP_MAX ? CLAMP_MAX : x).
- Output width equals input width; no saturation is needed beyond CLAMP.
- Negative counter accumulates the popcount of negative lanes on each in_fire.
  - On the in_fire of the last beat, the total (including that beat) is copied to a holding register and the accumulator resets to 0.
  - neg_count is presented with neg_count_valid on the cycle that the matching out_last beat fires (out_fire & out_last).
  - neg_count holds its value until the next frame completes.
- Simultaneous accumulator clear and new first beat: the new beat's negatives start the fresh count.
- Reset mid-frame: pipeline contents are discarded, counters go to 0 and the partial frame is abandoned. The next accepted beat is beat 0.

Decomposition:
- Package act_pkg holds:
  - typedef enum logic[1:0] act_mode_e {ACT_PASS, ACT_RELU, ACT_LEAKY, ACT_CLAMP}
  - default BITWIDTH constant
  - a function to popcount sign bits
- Sub-module act_lane is combinational, one element plus mode giving one result, parametrised by BITWIDTH, LEAKY_SHIFT and CLAMP_MAX. It is instantiated LANES times in a generate loop. It is reusable by act layers elsewhere.

Test Plan:
- Mode RELU, one frame, out_ready=1. Lane values {1,2,3,-1145}, {0,0,0,0}, {-1,-2,5,7}. Required out: {1,2,3,0}, {0,0,0,0}, {0,0,5,7}; out_last on beat 3; neg_count=3 pulsed with out_last; first out_valid 2 cycles after first in_fire.
- Mode LEAKY, input {-1145,-8,-1,16}. Required out {-144,-1,-1,16}.
- Mode CLAMP, input {-5,4,6,1000}. Required out {0,4,6,6}. PASS returns input bit-exact, including 32'h8000_0000.
- Backpressure: stream 2 frames while toggling out_ready 1/0 per cycle. Required: output order matches input, no loss, data stable while stalled. in_ready is low only when both stages are full and out_ready=0.
- Mode changes on the 2nd beat of a frame (RELU->PASS). Required: the whole frame uses RELU and the next frame uses PASS.
- Assert rst after beat 1 of a frame. Required next cycle: out_valid=0 and neg_count_valid=0. The next frame then produces correct out_last and a neg_count that excludes the pre-reset beats.
